rotate_sequencer: RTL and testbench

Multi-cycle rotate-left engine for 8-bit bytes. Accepts a byte and a rotate amount of 0–31 over a valid/ready handshake. Decomposes the amount (mod 8) into passes of at most 3 positions through the existing 2-bit-controlled 8-bit rotator `leftShift`, which it both feeds and consumes. Presents the result downstream over a second valid/ready handshake. Sits directly in front of the byte-permutation datapath; it is the only driver of the rotator's `I` and `shift` inputs.

---
 rtl/rot_pkg.sv | 13 +
 rtl/rotate_sequencer_leftshift.sv | 22 ++
 rtl/rotate_sequencer.sv | 96 +++++++++
 tb/tb_rotate_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the multi-cycle byte rotate engine.
package rot_pkg;

    localparam int ROT_W        = 8;
    localparam int ROT_STEP_MAX = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rot_state_t;

endpackage

// File: rtl/rotate_sequencer_leftshift.sv
// leftShift: 8-bit rotate-left by 0..3 positions, selected by a 2-bit control.
module leftShift
    import rot_pkg::*;
(
    input  logic [ROT_W-1:0] I,
    input  logic [1:0]       shift,
    output logic [ROT_W-1:0] out
);

    // Pure combinational rotate; bits leaving the MSB re-enter at the LSB.
    always_comb begin
        out = I;
        case (shift)
            2'd0: out = I;
            2'd1: out = {I[ROT_W-2:0], I[ROT_W-1]};
            2'd2: out = {I[ROT_W-3:0], I[ROT_W-1:ROT_W-2]};
            2'd3: out = {I[ROT_W-4:0], I[ROT_W-1:ROT_W-3]};
            default: out = I;
        endcase
    end

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: rotates a byte left by (amt mod 8) using repeated passes
// of at most three positions through a single leftShift instance.
// Jobs are accepted in IDLE, iterated in ROT and presented in DONE; there is
// no overlap between consecutive jobs.
module rotate_sequencer
    import rot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROT_W-1:0] in_data,
    input  logic [4:0]       in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROT_W-1:0] out_data,
    output logic [1:0]       out_passes
);

    rot_state_t       state_q, state_d;
    logic [ROT_W-1:0] data_q, data_d;
    logic [2:0]       rem_q, rem_d;
    logic [1:0]       passes_q, passes_d;

    logic [1:0]       step;
    logic [2:0]       rem_after;
    logic [ROT_W-1:0] rot_out;

    // Largest pass the rotator can do is three positions; clamp the remainder.
    always_comb begin
        step      = (rem_q > 3'(ROT_STEP_MAX)) ? 2'(ROT_STEP_MAX) : rem_q[1:0];
        rem_after = rem_q - {1'b0, step};
    end

    leftShift u_rot (
        .I     (data_q),
        .shift (step),
        .out   (rot_out)
    );

    // Next-state, datapath updates and handshake decode.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rem_d    = rem_q;
        passes_d = passes_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = in_data;
                    rem_d    = in_amt[2:0];
                    passes_d = 2'd0;
                    state_d  = (in_amt[2:0] == 3'd0) ? DONE : ROT;
                end
            end
            ROT: begin
                data_d   = rot_out;
                rem_d    = rem_after;
                passes_d = passes_q + 2'd1;
                if (rem_after == 3'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            rem_q    <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rem_q    <= rem_d;
            passes_q <= passes_d;
        end
    end

    // Outputs depend only on registered state, never on live inputs.
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        out_data   = data_q;
        out_passes = passes_q;
    end

endmodule

// File: tb/tb_rotate_sequencer.sv
// Testbench for rotate_sequencer: directed cases, backpressure, reset
// mid-job and a randomized back-to-back run against a rotate-left model.
module tb_rotate_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [4:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_passes;

    int errors = 0;
    int checks = 0;

    rotate_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_passes (out_passes)
    );

    always #5 clk = ~clk;

    // Reference: out[i] = in[(i - k) mod 8], k = amt mod 8.
    function automatic logic [7:0] model_rot(input logic [7:0] d, input int amt);
        logic [7:0] r;
        int k;
        k = amt % 8;
        for (int i = 0; i < 8; i++) r[i] = d[(i - k + 8) % 8];
        return r;
    endfunction

    // Reference: ceil((amt mod 8) / 3).
    function automatic int model_passes(input int amt);
        return ((amt % 8) + 2) / 3;
    endfunction

    // Drives one job from IDLE with out_ready held high; reports the result
    // and the cycle offset (relative to the accept cycle) of out_valid.
    task automatic run_job(input logic [7:0] d, input logic [4:0] a,
                           output logic [7:0] rd, output logic [1:0] rp,
                           output int lat);
        out_ready = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = out_data;
        rp = out_passes;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_amt = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_passes !== 2'd0) begin errors++; $display("FAIL reset_out_passes got=%0d exp=0", out_passes); end
        // A job offered during reset must not be taken.
        in_valid = 1'b1; in_data = 8'hA5; in_amt = 5'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wins_accept got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic [4:0] a;
        logic [7:0] exp_d;
        logic [1:0] exp_p;
        int         exp_lat;
    } dcase_t;

    task automatic test_directed();
        dcase_t tbl[5];
        logic [7:0] rd;
        logic [1:0] rp;
        int lat;
        tbl[0] = '{8'h81, 5'd1,  8'h03, 2'd1, 2};
        tbl[1] = '{8'h01, 5'd7,  8'h80, 2'd3, 4};
        tbl[2] = '{8'hA5, 5'd8,  8'hA5, 2'd0, 1};
        tbl[3] = '{8'hA5, 5'd0,  8'hA5, 2'd0, 1};
        tbl[4] = '{8'h01, 5'd13, 8'h20, 2'd2, 3};
        foreach (tbl[i]) begin
            run_job(tbl[i].d, tbl[i].a, rd, rp, lat);
            checks++; if (rd !== tbl[i].exp_d) begin errors++; $display("FAIL dir%0d_data got=%h exp=%h", i, rd, tbl[i].exp_d); end
            checks++; if (rp !== tbl[i].exp_p) begin errors++; $display("FAIL dir%0d_passes got=%0d exp=%0d", i, rp, tbl[i].exp_p); end
            checks++; if (lat != tbl[i].exp_lat) begin errors++; $display("FAIL dir%0d_latency got=A+%0d exp=A+%0d", i, lat, tbl[i].exp_lat); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_data = 8'h0F; in_amt = 5'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        // Competing job held on the inputs while the first one is stalled.
        in_data = 8'h33; in_amt = 5'd1;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b exp=1", out_valid); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_data !== 8'hF0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got data=%h valid=%b in_ready=%b exp F0/1/0", c, out_data, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        checks++; if (out_data !== 8'hF0 || out_passes !== 2'd2) begin
            errors++; $display("FAIL bp_result got=%h/%0d exp=F0/2", out_data, out_passes);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (out_data !== 8'h66 || out_passes !== 2'd1) begin
            errors++; $display("FAIL bp_second_job got=%h/%0d exp=66/1", out_data, out_passes);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_rot();
        logic [7:0] rd;
        logic [1:0] rp;
        int lat;
        out_ready = 1'b1;
        in_data = 8'h01; in_amt = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            errors++; $display("FAIL midrot_reset got valid=%b in_ready=%b data=%h exp 0/1/00", out_valid, in_ready, out_data);
        end
        run_job(8'h01, 5'd2, rd, rp, lat);
        checks++; if (rd !== 8'h04 || rp !== 2'd1) begin
            errors++; $display("FAIL midrot_next_job got=%h/%0d exp=04/1", rd, rp);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expq[$];
        int got = 0;
        fork
            begin : driver
                for (int j = 0; j < 500; j++) begin
                    int guard;
                    in_data  = 8'($urandom);
                    in_amt   = 5'($urandom);
                    in_valid = 1'b1;
                    guard = 0;
                    while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
                    expq.push_back({model_rot(in_data, int'(in_amt)), 2'(model_passes(int'(in_amt)))});
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                end
            end
            begin : monitor
                int cyc;
                logic stalled;
                logic [7:0] held_d;
                logic [1:0] held_p;
                logic [9:0] e;
                stalled = 1'b0; held_d = '0; held_p = '0;
                cyc = 0;
                while (got < 500 && cyc < 30000) begin
                    @(posedge clk); #2;
                    cyc++;
                    if (stalled) begin
                        checks++; if (out_valid !== 1'b1 || out_data !== held_d || out_passes !== held_p) begin
                            errors++; $display("FAIL b2b_hold got=%b/%h/%0d exp=1/%h/%0d", out_valid, out_data, out_passes, held_d, held_p);
                        end
                    end
                    out_ready = ($urandom_range(0, 9) < 6);
                    if (out_valid && out_ready) begin
                        if (expq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL b2b_spurious got data=%h exp no output", out_data);
                        end else begin
                            e = expq.pop_front();
                            checks++; if (out_data !== e[9:2]) begin errors++; $display("FAIL b2b_data job%0d got=%h exp=%h", got, out_data, e[9:2]); end
                            checks++; if (out_passes !== e[1:0]) begin errors++; $display("FAIL b2b_passes job%0d got=%0d exp=%0d", got, out_passes, e[1:0]); end
                        end
                        got++;
                    end
                    stalled = out_valid && !out_ready;
                    held_d = out_data;
                    held_p = out_passes;
                end
                checks++; if (got != 500) begin errors++; $display("FAIL b2b_count got=%0d exp=500", got); end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_rot();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
